// File: rtl/gardner_loop_nco.sv
// Gardner timing-recovery back-end: PI loop filter steering a decrementing modulo NCO.
// Define GARDNER_LOCK_DET_EN to build the lock detector; otherwise locked is tied low.
module gardner_loop_nco #(
  parameter int WIDTH     = 16,
  parameter int NCO_WIDTH = 24,
  parameter int SPS_LOG2  = 5,
  parameter int KP_SHIFT  = 4,
  parameter int KI_SHIFT  = 10,
  parameter int INT_LIM   = 131072,
  parameter int STEP_DEV  = 65536
) (
  input  logic                        clk_32M768,
  input  logic                        rst_n,
  input  logic                        enable,
  input  logic signed [WIDTH-1:0]     error_n,
  output logic                        strobe,
  output logic [15:0]                 mu,
  output logic signed [NCO_WIDTH-1:0] loop_out,
  output logic                        locked
);

  localparam int SW       = NCO_WIDTH + 2;
  localparam int W0_I     = 2 ** (NCO_WIDTH - SPS_LOG2);
  localparam int MU_SHIFT = NCO_WIDTH - SPS_LOG2 - 16;

  localparam logic [NCO_WIDTH-1:0]  W0       = NCO_WIDTH'(W0_I);
  localparam logic [NCO_WIDTH-1:0]  NCO_INIT = '1;
  localparam logic [NCO_WIDTH-1:0]  MU_MAX   = NCO_WIDTH'(16'hFFFF);
  localparam logic signed [SW-1:0]  INT_MAX  = SW'(INT_LIM);
  localparam logic signed [SW-1:0]  INT_MIN  = SW'(-INT_LIM);
  localparam logic signed [SW-1:0]  STEP_MIN = SW'(W0_I - STEP_DEV);
  localparam logic signed [SW-1:0]  STEP_MAX = SW'(W0_I + STEP_DEV);
  localparam logic signed [SW-1:0]  OUT_MAX  = SW'(2 ** (NCO_WIDTH - 1) - 1);
  localparam logic signed [SW-1:0]  OUT_MIN  = SW'(-(2 ** (NCO_WIDTH - 1)));

  function automatic logic [15:0] sat_mu(input logic [NCO_WIDTH-1:0] x);
    logic [NCO_WIDTH-1:0] s;
    s = x >> MU_SHIFT;
    if (s > MU_MAX) return 16'hFFFF;
    return s[15:0];
  endfunction

  function automatic logic signed [SW-1:0] sat_integ(input logic signed [SW-1:0] x);
    if (x > INT_MAX) return INT_MAX;
    if (x < INT_MIN) return INT_MIN;
    return x;
  endfunction

  function automatic logic [NCO_WIDTH-1:0] clamp_step(input logic signed [SW-1:0] x);
    logic signed [SW-1:0] t;
    t = SW'(W0_I) + x;
    if (t > STEP_MAX) t = STEP_MAX;
    if (t < STEP_MIN) t = STEP_MIN;
    return t[NCO_WIDTH-1:0];
  endfunction

  function automatic logic signed [NCO_WIDTH-1:0] sat_out(input logic signed [SW-1:0] x);
    logic signed [SW-1:0] t;
    t = x;
    if (t > OUT_MAX) t = OUT_MAX;
    if (t < OUT_MIN) t = OUT_MIN;
    return t[NCO_WIDTH-1:0];
  endfunction

  logic [NCO_WIDTH-1:0] nco;
  logic [NCO_WIDTH-1:0] step;
  logic signed [SW-1:0] integ;
  logic signed [SW-1:0] e_ext;
  logic signed [SW-1:0] integ_next;
  logic signed [SW-1:0] v;
  logic                 underflow;

  assign e_ext      = SW'(error_n);
  assign integ_next = sat_integ(integ + (e_ext >>> KI_SHIFT));
  assign v          = (e_ext >>> KP_SHIFT) + integ_next;
  assign underflow  = (nco < step);

  // NCO: the plain subtract wraps modulo 2^NCO_WIDTH, so no explicit add-back is needed
  always_ff @(posedge clk_32M768 or negedge rst_n) begin
    if (!rst_n) begin
      nco      <= NCO_INIT;
      step     <= W0;
      integ    <= '0;
      loop_out <= '0;
      strobe   <= 1'b0;
      mu       <= '0;
    end else begin
      nco    <= nco - step;
      strobe <= underflow;
      if (underflow) mu <= sat_mu(nco);
      if (!enable) begin
        integ    <= '0;
        loop_out <= '0;
        step     <= W0;
      end else if (strobe) begin
        integ    <= integ_next;
        loop_out <= sat_out(v);
        step     <= clamp_step(v);
      end
    end
  end

`ifdef GARDNER_LOCK_DET_EN
  localparam logic signed [SW-1:0] LOCK_THR = SW'(2048);

  logic [5:0] below_cnt;
  logic [2:0] above_cnt;
  logic       below_thr;

  assign below_thr = (e_ext < LOCK_THR) && (e_ext > -LOCK_THR);

  // Lock detector: 64 quiet strobes to lock, 8 noisy strobes in a row to drop it
  always_ff @(posedge clk_32M768 or negedge rst_n) begin
    if (!rst_n) begin
      below_cnt <= '0;
      above_cnt <= '0;
      locked    <= 1'b0;
    end else if (!enable) begin
      below_cnt <= '0;
      above_cnt <= '0;
      locked    <= 1'b0;
    end else if (strobe) begin
      if (below_thr) begin
        above_cnt <= '0;
        if (below_cnt == 6'd63) locked <= 1'b1;
        else below_cnt <= below_cnt + 6'd1;
      end else begin
        below_cnt <= '0;
        if (locked) begin
          if (above_cnt == 3'd7) begin
            locked    <= 1'b0;
            above_cnt <= '0;
          end else begin
            above_cnt <= above_cnt + 3'd1;
          end
        end else begin
          above_cnt <= '0;
        end
      end
    end
  end
`else
  assign locked = 1'b0;
`endif

endmodule

// File: tb/tb_gardner_loop_nco.sv
// Directed bench for gardner_loop_nco; integrator and step limits are narrowed so saturation is reachable quickly.
module tb_gardner_loop_nco;

  localparam int INT_LIM_T  = 8192;
  localparam int STEP_DEV_T = 8192;
`ifdef GARDNER_LOCK_DET_EN
  localparam logic LOCK_EN = 1'b1;
`else
  localparam logic LOCK_EN = 1'b0;
`endif

  logic               clk_32M768 = 1'b0;
  logic               rst_n      = 1'b0;
  logic               enable     = 1'b0;
  logic signed [15:0] error_n    = '0;
  logic               strobe;
  logic [15:0]        mu;
  logic signed [23:0] loop_out;
  logic               locked;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_32M768 = ~clk_32M768;

  gardner_loop_nco #(
    .INT_LIM (INT_LIM_T),
    .STEP_DEV(STEP_DEV_T)
  ) dut (
    .clk_32M768(clk_32M768),
    .rst_n     (rst_n),
    .enable    (enable),
    .error_n   (error_n),
    .strobe    (strobe),
    .mu        (mu),
    .loop_out  (loop_out),
    .locked    (locked)
  );

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_32M768);
    #1;
  endtask

  task automatic wait_strobe(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!strobe && n < 100);
    check("strobe_seen", strobe, 1);
  endtask

  initial begin
    int n;
    int total;
    int min_step;

    repeat (3) tick();
    check("rst_strobe", strobe, 0);
    check("rst_mu", mu, 0);
    check("rst_loop_out", loop_out, 0);
    check("rst_locked", locked, 0);

    // Open loop after reset release
    rst_n = 1'b1;
    wait_strobe(n);
    check("first_strobe_lat", n, 32);
    check("first_mu", mu, 16'hFFFF);
    wait_strobe(n);
    check("open_period", n, 32);
    check("open_mu", mu, 16'hFFFF);
    check("open_loop_out", loop_out, 0);
    check("open_step", dut.step, 524288);

    // Closed loop, constant positive error
    enable  = 1'b1;
    error_n = 16'sd4096;
    tick();
    check("cl1_loop_out", loop_out, 260);
    check("cl1_step", dut.step, 524548);
    check("cl1_integ", dut.integ, 4);
    wait_strobe(n);
    check("cl1_period", n + 1, 32);
    check("cl1_mu", mu, 64560);
    tick();
    check("cl2_loop_out", loop_out, 264);
    check("cl2_step", dut.step, 524552);
    wait_strobe(n);
    check("cl2_period", n + 1, 32);
    check("cl2_mu", mu, 63505);
    total = 0;
    for (int i = 0; i < 64; i++) begin
      wait_strobe(n);
      total += n;
    end
    check("cl_period_shortens", (total < 64 * 32), 1);

    // Most negative error: integrator saturates, step clamps
    error_n  = 16'sh8000;
    min_step = 524288;
    for (int i = 0; i < 320; i++) begin
      wait_strobe(n);
      if (int'(dut.step) < min_step) min_step = int'(dut.step);
    end
    check("sat_integ", dut.integ, -INT_LIM_T);
    check("sat_loop_out", loop_out, -2048 - INT_LIM_T);
    check("sat_step", dut.step, 524288 - STEP_DEV_T);
    check("sat_min_step", min_step, 524288 - STEP_DEV_T);

    // Enable dropped in a strobe cycle
    enable = 1'b0;
    tick();
    check("drop_integ", dut.integ, 0);
    check("drop_step", dut.step, 524288);
    check("drop_loop_out", loop_out, 0);
    wait_strobe(n);
    check("drop_no_gap", (n + 1 >= 32 && n + 1 <= 33), 1);
    wait_strobe(n);
    check("drop_period", n, 32);

    // Reset asserted mid-symbol
    enable  = 1'b1;
    error_n = 16'sd4096;
    repeat (10) tick();
    check("pre_rst_loop_out", loop_out, 260);
    rst_n = 1'b0;
    #1;
    check("mid_rst_strobe", strobe, 0);
    check("mid_rst_mu", mu, 0);
    check("mid_rst_loop_out", loop_out, 0);
    check("mid_rst_locked", locked, 0);
    check("mid_rst_integ", dut.integ, 0);
    enable  = 1'b0;
    error_n = '0;
    tick();
    tick();
    rst_n = 1'b1;
    wait_strobe(n);
    check("rerst_strobe_lat", n, 32);
    check("rerst_mu", mu, 16'hFFFF);

    // Lock detector: small error then large error
    enable  = 1'b1;
    error_n = 16'sd100;
    for (int i = 2; i <= 64; i++) wait_strobe(n);
    check("lock_before_64", locked, 0);
    tick();
    check("lock_after_64", locked, LOCK_EN);
    check("lock_loop_out", loop_out, 6);
    error_n = -16'sd3000;
    for (int i = 1; i <= 8; i++) begin
      wait_strobe(n);
      if (i == 2) check("unlock_loop_out", loop_out, -191);
    end
    check("unlock_before_8", locked, LOCK_EN);
    tick();
    check("unlock_after_8", locked, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
